key_state_decoder: RTL
======================

KEY_STATE_DECODER -- requirements
Module: key_state_decoder

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, meaning the number of tracked keys (legal range 1..8).
REQ-002 The module SHALL have parameter KEY_CODES, default {9'h174, 9'h16B, 9'h172, 9'h175}, meaning N_KEYS packed 9-bit codes; bit 8 is the E0-extended flag, bits 7:0 are the scan code, and slice i maps to key[i] (default: key[0]=up, key[1]=down, key[2]=left, key[3]=right).
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 65_000_000, meaning the stuck-key timeout in clk cycles (1 s at 65 MHz).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port rx_data, input, 8 bits: received PS/2 byte, already in the clk domain.
REQ-007 The module SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-008 The module SHALL have port key, output, N_KEYS bits: level, 1 while the mapped key is held.
REQ-009 The module SHALL have port key_press, output, N_KEYS bits: one-cycle pulse on each 0->1 transition of key.
REQ-010 The module SHALL have port key_release, output, N_KEYS bits: one-cycle pulse on each 1->0 transition of key.
REQ-011 The module SHALL have port any_key, output, 1 bit: OR of key.
REQ-012 The module SHALL have port seq_err, output, 1 bit: one-cycle pulse on an illegal byte sequence.

Function
REQ-013 The parser SHALL be an FSM with states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0) and SKIP (Pause sequence); it SHALL advance only on cycles with rx_valid=1.
REQ-014 In IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter=7; any other byte SHALL be a make of code {1'b0,byte}, and the FSM SHALL stay in IDLE.
REQ-015 In EXT: F0->EXT_BRK; any other byte SHALL be a make of {1'b1,byte}, then IDLE.
REQ-016 In BRK or EXT_BRK: the byte SHALL be a break of {ext,byte}, then IDLE.
REQ-017 In SKIP: each byte SHALL decrement the counter, and the FSM SHALL return to IDLE when it reaches 0; no key is affected.
REQ-018 The bytes E0, F0 or E1 received in EXT/BRK/EXT_BRK SHALL pulse seq_err, discard the partial sequence, and return to IDLE.
REQ-019 A make matching KEY_CODES slice i SHALL set key[i]; a break matching slice i SHALL clear key[i]; unmapped codes SHALL be ignored.
REQ-020 key SHALL update in the cycle after the rx_valid of the final byte; key_press/key_release SHALL pulse in that same cycle.
REQ-021 A typematic repeat make for an already-held key SHALL leave key unchanged and SHALL produce no key_press.
REQ-022 A break for a key that is not held SHALL produce no key_release and no seq_err.
REQ-023 Duplicate entries in KEY_CODES SHALL update all matching bits.

Reset
REQ-024 When rst=1 at a clock edge, the FSM SHALL go to IDLE, the skip counter and timeout counter SHALL clear, and key, key_press, key_release, any_key and seq_err SHALL all be 0 in the following cycle.
REQ-025 Reset mid-sequence (e.g. after E0) SHALL discard the sequence; a following byte SHALL be parsed from IDLE.
REQ-026 rst SHALL take priority over a simultaneous rx_valid, and that byte SHALL be dropped.

Configuration
REQ-027 With macro KEY_STUCK_TIMEOUT_EN defined, a counter SHALL clear on every rx_valid and otherwise increment while any_key=1; on reaching TIMEOUT_CYC-1 it SHALL clear all key bits, pulse key_release for each held key, and reset to 0.
REQ-028 Without KEY_STUCK_TIMEOUT_EN, no timeout counter SHALL exist and keys SHALL remain held until their break code.
REQ-029 A timeout and an rx_valid in the same cycle SHALL give rx_valid precedence, with the counter cleared and no release.

Verification
REQ-030 Directed test: bytes 75 (non-extended) -> no key change; bytes E0,75 -> key=4'b0001 and key_press=4'b0001 for one cycle after the second strobe.
REQ-031 Directed test: E0,75 then E0,75 repeated 5 times -> key_press pulses exactly once and key stays 4'b0001.
REQ-032 Directed test: with key=4'b0101, sending E0,F0,72 (down, not held) -> no change; then E0,F0,75 -> key=4'b0100 and key_release=4'b0001.
REQ-033 Directed test: E0,F0,F0 -> seq_err pulses once; the next E0,6B sets key[2].
REQ-034 Directed test: E1,14,77,E1,F0,14,F0,77 -> no key change and no seq_err; E0,74 afterwards sets key[3].
REQ-035 Directed test: with KEY_STUCK_TIMEOUT_EN and TIMEOUT_CYC=100, press up then send no bytes -> key[0] clears 100 cycles after the last strobe with a key_release pulse; rst asserted after E0 -> the next byte 75 is parsed as non-extended.

Source files
------------

// File: rtl/key_state_decoder.sv
// ============================================================================
// key_state_decoder
// ----------------------------------------------------------------------------
// Turns a stream of PS/2 set-2 scan-code bytes into held-key levels for a
// small set of tracked keys. It handles make codes, break codes (F0 prefix),
// extended codes (E0 prefix) and the eight-byte Pause sequence (E1 prefix),
// which it skips. Byte sequences that cannot occur are reported on seq_err
// and discarded.
//
// Optional feature (compile-time macro KEY_STUCK_TIMEOUT_EN):
//   If a key stays held for TIMEOUT_CYC cycles with no byte received, all
//   keys are released. This recovers from a lost break code. A byte received
//   in the same cycle wins, and the timeout count restarts.
//
// Parameters:
//   N_KEYS      - number of tracked keys (1..8)
//   KEY_CODES   - N_KEYS packed 9-bit codes. Bit 8 is the E0 flag and bits
//                 7:0 are the scan code. Slice i drives key[i].
//   TIMEOUT_CYC - stuck-key timeout in clk cycles
//
// Ports:
//   clk         - single clock; all logic runs on its rising edge
//   rst         - synchronous, active-high reset
//   rx_data     - received PS/2 byte, already in the clk domain
//   rx_valid    - one-cycle strobe that qualifies rx_data
//   key         - level, 1 while the mapped key is held
//   key_press   - one-cycle pulse when a key bit goes 0->1
//   key_release - one-cycle pulse when a key bit goes 1->0
//   any_key     - OR of key
//   seq_err     - one-cycle pulse on an illegal byte sequence
// ============================================================================
module key_state_decoder #(
    parameter int                    N_KEYS      = 4,
    parameter logic [N_KEYS*9-1:0]   KEY_CODES   = {9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                    TIMEOUT_CYC = 65_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              any_key,
    output logic              seq_err
);

    // Prefix bytes of the PS/2 set-2 protocol.
    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BRK   = 8'hF0;
    localparam logic [7:0] BYTE_PAUSE = 8'hE1;

    // Pause is E1 followed by seven more bytes, and none of them carry key state.
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    // Parser states.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [2:0]        skip_cnt;
    logic [2:0]        skip_next;

    logic              make_evt;
    logic              brk_evt;
    logic              err_evt;
    logic              ext_flag;
    logic [8:0]        code;
    logic [N_KEYS-1:0] code_match;
    logic [N_KEYS-1:0] key_next;
    logic              timeout_hit;

    // A prefix byte is never a complete key code. Seeing one where a code
    // is expected means the stream is corrupt.
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == BYTE_EXT) || (b == BYTE_BRK) || (b == BYTE_PAUSE);
    endfunction

    // ------------------------------------------------------------------------
    // Parser next-state logic. It acts only when rx_valid is high. A make or
    // break event is produced on the final byte of a sequence and carries
    // the E0 flag that was collected along the way.
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        make_evt   = 1'b0;
        brk_evt    = 1'b0;
        err_evt    = 1'b0;
        ext_flag   = 1'b0;

        if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_data == BYTE_EXT) begin
                        state_next = ST_EXT;
                    end else if (rx_data == BYTE_BRK) begin
                        state_next = ST_BRK;
                    end else if (rx_data == BYTE_PAUSE) begin
                        state_next = ST_SKIP;
                        skip_next  = PAUSE_TAIL;
                    end else begin
                        make_evt = 1'b1;
                    end
                end

                ST_EXT: begin
                    ext_flag = 1'b1;
                    if (rx_data == BYTE_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (is_prefix(rx_data)) begin
                        err_evt    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        make_evt   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end

                ST_BRK, ST_EXT_BRK: begin
                    ext_flag   = (state == ST_EXT_BRK);
                    state_next = ST_IDLE;
                    if (is_prefix(rx_data)) begin
                        err_evt = 1'b1;
                    end else begin
                        brk_evt = 1'b1;
                    end
                end

                ST_SKIP: begin
                    // The count still holds this byte's position, so a value
                    // of 1 means this is the last byte of the Pause sequence.
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        skip_next  = 3'd0;
                        state_next = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                    skip_next  = 3'd0;
                end
            endcase
        end
    end

    assign code = {ext_flag, rx_data};

    // ------------------------------------------------------------------------
    // Compare the decoded code against every table entry. Duplicate entries
    // are allowed on purpose, so one code may drive several key bits.
    // ------------------------------------------------------------------------
    always_comb begin
        code_match = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            code_match[i] = (KEY_CODES[i*9 +: 9] == code);
        end
    end

    // ------------------------------------------------------------------------
    // New key levels. A make ORs bits in, so a typematic repeat of a held
    // key changes nothing. A break masks bits out, so releasing a key that
    // is not held changes nothing. A timeout can only fire when no byte
    // arrives, and it drops every key.
    // ------------------------------------------------------------------------
    always_comb begin
        key_next = key;
        if (make_evt) begin
            key_next = key | code_match;
        end else if (brk_evt) begin
            key_next = key & ~code_match;
        end else if (timeout_hit) begin
            key_next = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Parser state, key levels and event pulses. The edge pulses come from
    // comparing the old level with the new one, so they always line up with
    // the cycle in which key changes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            skip_cnt    <= 3'd0;
            key         <= '0;
            key_press   <= '0;
            key_release <= '0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_next;
            skip_cnt    <= skip_next;
            key         <= key_next;
            key_press   <= key_next & ~key;
            key_release <= key & ~key_next;
            seq_err     <= err_evt;
        end
    end

    assign any_key = |key;

`ifdef KEY_STUCK_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // The timeout fires on the last cycle of a quiet period while a key is
    // held. Any received byte in that same cycle suppresses it.
    assign timeout_hit = !rx_valid && any_key && (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------------
    // Stuck-key counter. It restarts on every byte and counts quiet cycles
    // while a key is held. It wraps to 0 when the timeout fires. Every path
    // that clears the last key either receives a byte or fires the timeout,
    // so the counter is already 0 whenever no key is held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (rx_valid || timeout_hit) begin
            tmo_cnt <= '0;
        end else if (any_key) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // With the timeout logic not built, keys are released only by their
    // break code. This term is constant 0 for any legal TIMEOUT_CYC; it only
    // keeps the parameter referenced in this build.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

endmodule
